// File: rtl/uparc_ifu_if.sv
// Fetch-stage / instruction-bus signal bundle for the uparc IFU.
// slave = the IFU itself, master = fetch stage plus instruction bus side.
`ifndef UPARC_ADDR_WIDTH
`define UPARC_ADDR_WIDTH 32
`endif
`ifndef UPARC_INSTR_WIDTH
`define UPARC_INSTR_WIDTH 32
`endif

interface uparc_ifu_if;
  logic [`UPARC_ADDR_WIDTH-1:0]  i_addr;
  logic                          i_rd_cmd;
  logic [`UPARC_INSTR_WIDTH-1:0] o_instr_dat;
  logic                          o_busy;
  logic                          o_err_align;
  logic                          o_err_bus;
  logic [`UPARC_ADDR_WIDTH-1:0]  o_bus_addr;
  logic                          o_bus_req;
  logic                          i_bus_ack;
  logic                          i_bus_err;
  logic [`UPARC_INSTR_WIDTH-1:0] i_bus_rdata;

  modport slave (
    input  i_addr, i_rd_cmd, i_bus_ack, i_bus_err, i_bus_rdata,
    output o_instr_dat, o_busy, o_err_align, o_err_bus, o_bus_addr, o_bus_req
  );
  modport master (
    output i_addr, i_rd_cmd, i_bus_ack, i_bus_err, i_bus_rdata,
    input  o_instr_dat, o_busy, o_err_align, o_err_bus, o_bus_addr, o_bus_req
  );
endinterface

// File: rtl/uparc_ifu.sv
// Instruction fetch unit: one bus read per aligned fetch command, NOP plus error pulse on failure.
// Optional bus response timeout enabled by defining UPARC_IFU_BUS_TIMEOUT_EN.
`ifndef UPARC_ADDR_WIDTH
`define UPARC_ADDR_WIDTH 32
`endif
`ifndef UPARC_INSTR_WIDTH
`define UPARC_INSTR_WIDTH 32
`endif

module uparc_ifu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk,
  input logic      nrst,
  uparc_ifu_if.slave ifu
);
  localparam int AW = `UPARC_ADDR_WIDTH;
  localparam int IW = `UPARC_INSTR_WIDTH;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_instr_dat, w_instr_dat_nxt;
  logic [AW-1:0]   r_bus_addr, w_bus_addr_nxt;
  logic            r_bus_req, w_bus_req_nxt;
  logic            r_err_align, w_err_align_nxt;
  logic            r_err_bus, w_err_bus_nxt;
  logic            w_tmo;

`ifdef UPARC_IFU_BUS_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // Held at zero in IDLE so it starts from zero on every entry to WAIT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_tmo_cnt <= '0;
    else if (r_state == IDLE)
      r_tmo_cnt <= '0;
    else if (!ifu.i_bus_ack && !ifu.i_bus_err)
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  assign w_tmo = (r_state == WAIT) && (r_tmo_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_instr_dat <= '0;
      r_bus_addr  <= '0;
      r_bus_req   <= 1'b0;
      r_err_align <= 1'b0;
      r_err_bus   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_instr_dat <= w_instr_dat_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_err_align <= w_err_align_nxt;
      r_err_bus   <= w_err_bus_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_instr_dat_nxt = r_instr_dat;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_req_nxt   = r_bus_req;
    w_err_align_nxt = 1'b0;
    w_err_bus_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ifu.i_rd_cmd) begin
          if (ifu.i_addr[1:0] == 2'b00) begin
            w_bus_addr_nxt = ifu.i_addr;
            w_bus_req_nxt  = 1'b1;
            w_state_nxt    = WAIT;
          end else begin
            w_err_align_nxt = 1'b1;
            w_instr_dat_nxt = '0;
          end
        end
      end
      WAIT: begin
        // Bus error beats ack; a real response in the timeout cycle beats the timeout.
        if (ifu.i_bus_err || (w_tmo && !ifu.i_bus_ack)) begin
          w_instr_dat_nxt = '0;
          w_err_bus_nxt   = 1'b1;
          w_bus_req_nxt   = 1'b0;
          w_state_nxt     = IDLE;
        end else if (ifu.i_bus_ack) begin
          w_instr_dat_nxt = ifu.i_bus_rdata;
          w_bus_req_nxt   = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ifu.o_instr_dat = r_instr_dat;
  assign ifu.o_bus_addr  = r_bus_addr;
  assign ifu.o_bus_req   = r_bus_req;
  assign ifu.o_err_align = r_err_align;
  assign ifu.o_err_bus   = r_err_bus;
  assign ifu.o_busy      = ifu.i_rd_cmd | (r_state == WAIT);
endmodule

// File: tb/tb_uparc_ifu.sv
// Self-checking bench for uparc_ifu: directed cases plus randomized fetches vs a transaction-level model.
module tb_uparc_ifu;
`ifdef UPARC_IFU_BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  uparc_ifu_if bus ();
  uparc_ifu #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .nrst(nrst), .ifu(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_instr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_rd_cmd = 1'b0;
    bus.i_bus_ack = 1'b0;
    bus.i_bus_err = 1'b0;
  endtask

  // Idle cycles with random bus noise that must be ignored outside WAIT.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      idle_inputs();
      bus.i_bus_ack = 1'($urandom_range(0, 1));
      bus.i_bus_err = 1'($urandom_range(0, 1));
      bus.i_bus_rdata = $urandom;
      @(negedge clk);
      chk("idle_req", 32'(bus.o_bus_req), 32'd0);
      chk("idle_busy", 32'(bus.o_busy), 32'd0);
      chk("idle_errb", 32'(bus.o_err_bus), 32'd0);
      chk("idle_erra", 32'(bus.o_err_align), 32'd0);
      chk("idle_instr", bus.o_instr_dat, exp_instr);
    end
    step();
    idle_inputs();
  endtask

  // kind: 0 = ack, 1 = err, 2 = ack+err. viol injects a stray command inside WAIT.
  task automatic fetch(input logic [31:0] addr, input int waits, input int kind,
                       input logic [31:0] rdata, input bit viol);
    logic [31:0] new_instr;
    bit bad_align;
    bad_align = (addr[1:0] != 2'b00);
    new_instr = bad_align ? 32'd0 : (kind == 0 ? rdata : 32'd0);
    idle_inputs();
    bus.i_rd_cmd = 1'b1;
    bus.i_addr = addr;
    @(negedge clk);
    chk("busy_C", 32'(bus.o_busy), 32'd1);
    chk("req_C", 32'(bus.o_bus_req), 32'd0);
    if (bad_align) begin
      step();
      idle_inputs();
      bus.i_bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("align_err", 32'(bus.o_err_align), 32'd1);
      chk("align_nop", bus.o_instr_dat, 32'd0);
      chk("align_busy", 32'(bus.o_busy), 32'd0);
      chk("align_req", 32'(bus.o_bus_req), 32'd0);
      chk("align_errb", 32'(bus.o_err_bus), 32'd0);
      exp_instr = 32'd0;
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      step();
      idle_inputs();
      if (k == waits) begin
        bus.i_bus_ack = (kind != 1);
        bus.i_bus_err = (kind != 0);
        bus.i_bus_rdata = rdata;
      end else begin
        bus.i_bus_rdata = $urandom;
      end
      if (viol && k == 0 && waits > 0) begin
        bus.i_rd_cmd = 1'b1;
        bus.i_addr = $urandom;
      end
      @(negedge clk);
      chk("wait_req", 32'(bus.o_bus_req), 32'd1);
      chk("wait_addr", bus.o_bus_addr, addr);
      chk("wait_busy", 32'(bus.o_busy), 32'd1);
      chk("wait_instr", bus.o_instr_dat, exp_instr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    exp_instr = new_instr;
    chk("done_instr", bus.o_instr_dat, exp_instr);
    chk("done_errb", 32'(bus.o_err_bus), (kind != 0) ? 32'd1 : 32'd0);
    chk("done_erra", 32'(bus.o_err_align), 32'd0);
    chk("done_busy", 32'(bus.o_busy), 32'd0);
    chk("done_req", 32'(bus.o_bus_req), 32'd0);
  endtask

  initial begin
    int errs;
    logic [31:0] a;
    bus.i_addr = '0;
    bus.i_bus_rdata = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_instr", bus.o_instr_dat, 32'd0);
    chk("rst_addr", bus.o_bus_addr, 32'd0);
    chk("rst_req", 32'(bus.o_bus_req), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_errs", 32'({bus.o_err_align, bus.o_err_bus}), 32'd0);
    nrst = 1'b1;
    step();

    fetch(32'h0000_0100, 0, 0, 32'h2408_0005, 1'b0);
    idle(1);
    fetch(32'h0000_0100, 3, 0, 32'h1234_5678, 1'b0);
    idle(1);
    fetch(32'h0000_0102, 0, 0, 32'hdead_beef, 1'b0);
    idle(1);
    fetch(32'h0000_0200, 1, 2, 32'hcafe_f00d, 1'b0);
    idle(2);
    fetch(32'h0000_0300, 0, 0, 32'h0bad_cafe, 1'b0);
    idle(1);

    // Reset mid-transaction: response after release must be ignored.
    bus.i_rd_cmd = 1'b1;
    bus.i_addr = 32'h0000_0400;
    step();
    idle_inputs();
    @(negedge clk);
    chk("rstmid_req_pre", 32'(bus.o_bus_req), 32'd1);
    step();
    nrst = 1'b0;
    #1;
    chk("rstmid_req", 32'(bus.o_bus_req), 32'd0);
    chk("rstmid_instr", bus.o_instr_dat, 32'd0);
    chk("rstmid_addr", bus.o_bus_addr, 32'd0);
    chk("rstmid_busy", 32'(bus.o_busy), 32'd0);
    exp_instr = 32'd0;
    step();
    step();
    nrst = 1'b1;
    step();
    bus.i_bus_ack = 1'b1;
    bus.i_bus_rdata = 32'h5555_aaaa;
    step();
    idle_inputs();
    @(negedge clk);
    chk("rstmid_late_instr", bus.o_instr_dat, 32'd0);
    chk("rstmid_late_req", 32'(bus.o_bus_req), 32'd0);
    chk("rstmid_late_busy", 32'(bus.o_busy), 32'd0);
    idle(1);

    for (int t = 0; t < 60; t++) begin
      a = $urandom & 32'h0000_fffc;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      fetch(a, $urandom_range(0, 4), $urandom_range(0, 2), $urandom,
            1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    // No bus response at all.
    bus.i_rd_cmd = 1'b1;
    bus.i_addr = 32'h0000_0800;
    step();
    idle_inputs();
`ifdef UPARC_IFU_BUS_TIMEOUT_EN
    errs = 0;
    for (int i = 0; i < 3 * TMO + 10; i++) begin
      @(negedge clk);
      if (bus.o_err_bus) errs++;
      step();
    end
    chk("tmo_errb_once", 32'(errs), 32'd1);
    @(negedge clk);
    chk("tmo_req", 32'(bus.o_bus_req), 32'd0);
    chk("tmo_busy", 32'(bus.o_busy), 32'd0);
    chk("tmo_instr", bus.o_instr_dat, 32'd0);
    exp_instr = 32'd0;
`else
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.o_busy || !bus.o_bus_req || bus.o_err_bus) errs++;
      step();
    end
    chk("hang_busy", 32'(errs), 32'd0);
    bus.i_bus_ack = 1'b1;
    bus.i_bus_rdata = 32'h7777_0001;
    step();
    idle_inputs();
    @(negedge clk);
    exp_instr = 32'h7777_0001;
    chk("hang_done_instr", bus.o_instr_dat, exp_instr);
    chk("hang_done_busy", 32'(bus.o_busy), 32'd0);
`endif
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uparc_ifu.md
# uparc_ifu

Instruction fetch unit: the responder side of the fetch-stage IFU interface. It accepts one-cycle read commands from the fetch stage and checks word alignment. It runs one read transaction per command on the instruction bus. It returns the fetched word, or an error pulse, while asserting busy so the pipeline stalls for the whole transaction.

## Interface
- TIMEOUT_CYCLES, 255: bus response timeout in cycles. Used only with UPARC_IFU_BUS_TIMEOUT_EN; valid range 1..65535.
- clk  input  1  clock, all state on rising edge
- nrst  input  1  reset, asynchronous, active-low
- i_addr  input  `UPARC_ADDR_WIDTH  fetch address; sampled when i_rd_cmd=1
- i_rd_cmd  input  1  read command, one-cycle pulse from fetch stage
- o_instr_dat  output  `UPARC_INSTR_WIDTH  last fetched word (registered, held)
- o_busy  output  1  transaction in progress; fetch must stall
- o_err_align  output  1  misaligned-address pulse
- o_err_bus  output  1  bus-error pulse
- o_bus_addr  output  `UPARC_ADDR_WIDTH  instruction bus address (registered)
- o_bus_req  output  1  instruction bus read request (registered)
- i_bus_ack  input  1  read data valid this cycle
- i_bus_err  input  1  read failed this cycle
- i_bus_rdata  input  `UPARC_INSTR_WIDTH  read data; sampled when i_bus_ack=1

## Operation
- States: IDLE, WAIT.
- IDLE, i_rd_cmd=1, i_addr[1:0]=0:
  - Latch i_addr into o_bus_addr and set o_bus_req=1.
  - Go to WAIT.
- IDLE, i_rd_cmd=1, i_addr[1:0]!=0:
  - No bus request; stay IDLE.
  - Next cycle o_err_align=1 for one cycle and o_instr_dat=0 (NOP).
- WAIT:
  - o_bus_req and o_bus_addr are held stable until the response cycle.
  - i_bus_ack=1 and i_bus_err=0: o_instr_dat<=i_bus_rdata, o_bus_req<=0, go IDLE.
  - i_bus_err=1, regardless of ack; error wins: o_instr_dat<=0, o_err_bus<=1 for one cycle, o_bus_req<=0, go IDLE.
- o_busy = i_rd_cmd | (state==WAIT). This is combinational, so the fetch stage stalls in the command cycle itself.
- i_rd_cmd while in WAIT is a protocol violation and is ignored (no effect on the transaction).
- o_instr_dat changes only on completion (data or NOP). It is held indefinitely otherwise, so a downstream stall sees a stable word.
- o_err_align and o_err_bus are never both high; each is high for exactly one cycle per failed command.

## Timing
- Reset values: o_instr_dat=0, o_bus_addr=0, o_bus_req=0, o_err_align=0, o_err_bus=0, state=IDLE. o_busy=0 provided i_rd_cmd=0.
- Reset mid-transaction clears o_bus_req immediately (asynchronous) and abandons the transaction. A later i_bus_ack is ignored in IDLE.
- Cycle numbering:
  - Command in cycle C.
  - Earliest o_bus_req is cycle C+1.
  - Earliest ack is cycle C+1.
  - Data or error visible in cycle C+2, with o_busy=0 in that cycle.
- Minimum fetch latency is 2 cycles. Each wait-state cycle adds 1.
- Misaligned command: o_busy=1 in cycle C only; o_err_align and NOP in cycle C+1.
- i_bus_ack and i_bus_err are ignored outside WAIT.

## Configuration
- UPARC_IFU_BUS_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each cycle in WAIT without a response.
  - When it reaches TIMEOUT_CYCLES with no response, treat that cycle as i_bus_err=1: drop the request, NOP, o_err_bus pulse, go IDLE.
  - A response arriving in the timeout cycle takes priority over the timeout.
- Not defined: no counter; WAIT is held until i_bus_ack or i_bus_err, with no upper bound.

## Test plan
- Reset, then i_addr=0x0000_0100 with i_rd_cmd for 1 cycle; i_bus_ack with rdata=0x2408_0005 in cycle C+1 -> o_busy=1 in C and C+1; o_bus_req=1, o_bus_addr=0x100 in C+1; o_instr_dat=0x2408_0005, o_busy=0 in C+2.
- Same command with 3 wait states (ack in C+4) -> o_bus_req/o_bus_addr stable in C+1..C+4, o_busy=1 in C..C+4, data in C+5, o_instr_dat unchanged before C+5.
- i_addr=0x0000_0102 with i_rd_cmd -> o_bus_req never rises; o_err_align=1 and o_instr_dat=0 in C+1 only; o_busy=0 in C+1.
- i_bus_err and i_bus_ack both high in C+2 -> o_err_bus=1 in C+3 only, o_instr_dat=0, o_bus_req=0 in C+3.
- nrst low in C+2 of a pending fetch, released in C+4; i_bus_ack pulsed in C+5 -> o_bus_req=0 from assertion of reset, all outputs at reset values, no o_instr_dat update.
- With UPARC_IFU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no bus response -> o_err_bus=1 exactly once, o_bus_req=0 and o_busy=0 afterwards. Without the macro -> o_busy remains 1 for 1000 cycles.
